arp_cache_multi: RTL and testbench

Parametrised multi-entry ARP cache. It is the next generation of the single-entry cache that sits between the MAC RX path (learning from ARP replies and requests) and the MAC TX path (destination MAC resolution).
It holds DEPTH IP→MAC bindings with tick-based aging, free-slot/oldest-entry replacement and flush. It answers lookups with fixed 1-cycle latency.

---
 rtl/arp_cache_multi.sv | 162 ++++++++++++++++
 tb/tb_arp_cache_multi.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_cache_multi.sv
// arp_cache_multi
// Multi-entry IP->MAC cache with tick-based aging, free-slot / oldest-entry
// replacement and flush. Lookups answer with a fixed 1-cycle latency from
// the register state before any same-cycle learn/tick/flush.
//
// Ports:
//   clk                      single clock
//   rst_n                    synchronous active-low reset
//   arp_found                pulse: learn arp_rec_source_ip_addr -> arp_rec_source_mac_addr
//   arp_rec_source_ip_addr   IP to learn
//   arp_rec_source_mac_addr  MAC to learn
//   age_tick                 aging strobe
//   flush                    invalidate all entries (beats learn and tick)
//   lookup_req               pulse: resolve destination_ip_addr
//   destination_ip_addr      IP to resolve
//   lookup_done              pulse one cycle after lookup_req
//   destination_mac_addr     resolved MAC (all-ones on miss), held
//   mac_not_exist            1 = last lookup missed, held
//   entry_count              registered number of valid entries

module arp_cache_multi #(
    parameter int DEPTH   = 4,
    parameter int AGE_MAX = 300,
    parameter int AGE_W   = 9,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arp_found,
    input  logic [31:0]      arp_rec_source_ip_addr,
    input  logic [47:0]      arp_rec_source_mac_addr,
    input  logic             age_tick,
    input  logic             flush,
    input  logic             lookup_req,
    input  logic [31:0]      destination_ip_addr,
    output logic             lookup_done,
    output logic [47:0]      destination_mac_addr,
    output logic             mac_not_exist,
    output logic [CNT_W-1:0] entry_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(AGE_MAX);

    logic [DEPTH-1:0] valid_q;
    logic [31:0]      ip_q  [DEPTH];
    logic [47:0]      mac_q [DEPTH];
    logic [AGE_W-1:0] age_q [DEPTH];

    logic             lk_hit;
    logic [47:0]      lk_mac;
    logic             learn_en;
    logic [IDX_W-1:0] learn_idx;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim_idx;
    logic [AGE_W-1:0] victim_age;
    logic [CNT_W-1:0] cnt_c;

    // Parallel lookup; scanning from the top down lets the lowest index win.
    always_comb begin
        lk_hit = 1'b0;
        lk_mac = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == destination_ip_addr)) begin
                lk_hit = 1'b1;
                lk_mac = mac_q[i];
            end
        end
    end

    // Learn target: existing binding, else lowest free slot, else the oldest
    // entry (pre-tick ages, strict compare keeps the lowest index on ties).
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        victim_idx = '0;
        victim_age = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == arp_rec_source_ip_addr)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] > victim_age) begin
                victim_age = age_q[i];
                victim_idx = IDX_W'(i);
            end
        end
        learn_en = arp_found && !flush
                   && (arp_rec_source_ip_addr != 32'h0)
                   && (arp_rec_source_ip_addr != 32'hFFFF_FFFF);
        if (match_hit)
            learn_idx = match_idx;
        else if (free_hit)
            learn_idx = free_idx;
        else
            learn_idx = victim_idx;
    end

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_c = cnt_c + CNT_W'(valid_q[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q              <= '0;
            lookup_done          <= 1'b0;
            destination_mac_addr <= 48'h0;
            mac_not_exist        <= 1'b0;
            entry_count          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ip_q[i]  <= 32'h0;
                mac_q[i] <= 48'h0;
                age_q[i] <= '0;
            end
        end else begin
            lookup_done <= lookup_req;
            if (lookup_req) begin
                destination_mac_addr <= lk_hit ? lk_mac : 48'hFFFF_FFFF_FFFF;
                mac_not_exist        <= !lk_hit;
            end

            if (flush) begin
                valid_q <= '0;
                for (int i = 0; i < DEPTH; i++)
                    age_q[i] <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (learn_en && (learn_idx == IDX_W'(i))) begin
                        valid_q[i] <= 1'b1;
                        ip_q[i]    <= arp_rec_source_ip_addr;
                        mac_q[i]   <= arp_rec_source_mac_addr;
                        age_q[i]   <= '0;
                    end else if (age_tick && valid_q[i]) begin
                        if ((age_q[i] + AGE_W'(1)) == AGE_LIMIT) begin
                            valid_q[i] <= 1'b0;
                            age_q[i]   <= '0;
                        end else begin
                            age_q[i] <= age_q[i] + AGE_W'(1);
                        end
                    end
                end
            end

            // Counts the current valid set, so it trails a valid change by one cycle.
            entry_count <= cnt_c;
        end
    end

endmodule

// File: tb/tb_arp_cache_multi.sv
// Testbench for arp_cache_multi: directed scenarios followed by random
// traffic, checked against a behavioural cache model through a scoreboard.

module tb_arp_cache_multi;

    localparam int DEPTH   = 4;
    localparam int AGE_MAX = 3;
    localparam int AGE_W   = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arp_found;
    logic [31:0]      arp_rec_source_ip_addr;
    logic [47:0]      arp_rec_source_mac_addr;
    logic             age_tick;
    logic             flush;
    logic             lookup_req;
    logic [31:0]      destination_ip_addr;
    logic             lookup_done;
    logic [47:0]      destination_mac_addr;
    logic             mac_not_exist;
    logic [CNT_W-1:0] entry_count;

    arp_cache_multi #(
        .DEPTH(DEPTH), .AGE_MAX(AGE_MAX), .AGE_W(AGE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .arp_found(arp_found),
        .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
        .arp_rec_source_mac_addr(arp_rec_source_mac_addr),
        .age_tick(age_tick),
        .flush(flush),
        .lookup_req(lookup_req),
        .destination_ip_addr(destination_ip_addr),
        .lookup_done(lookup_done),
        .destination_mac_addr(destination_mac_addr),
        .mac_not_exist(mac_not_exist),
        .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [47:0] mac;
        logic        nx;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural cache: plain arrays, updated once per clock from the rules.
    bit          m_valid [DEPTH];
    logic [31:0] m_ip    [DEPTH];
    logic [47:0] m_mac   [DEPTH];
    int          m_age   [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] ip);
        exp_t e;
        e.mac = 48'hFFFF_FFFF_FFFF;
        e.nx  = 1'b1;
        e.cnt = model_count();
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_ip[i] == ip) begin
                e.mac = m_mac[i];
                e.nx  = 1'b0;
                break;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_ip[i] = 0; m_mac[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_update(input bit a, input logic [31:0] ip, input logic [47:0] mac,
                                input bit t, input bit f);
        int tgt = -1;
        if (f) begin
            for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_age[i] = 0; end
            return;
        end
        if (a && ip != 32'h0 && ip != 32'hFFFF_FFFF) begin
            for (int i = 0; i < DEPTH && tgt < 0; i++) if (m_valid[i] && m_ip[i] == ip) tgt = i;
            for (int i = 0; i < DEPTH && tgt < 0; i++) if (!m_valid[i]) tgt = i;
            if (tgt < 0) begin
                int best = -1;
                for (int i = 0; i < DEPTH; i++)
                    if (m_age[i] > best) begin best = m_age[i]; tgt = i; end
            end
        end
        if (t) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && i != tgt) begin
                    m_age[i]++;
                    if (m_age[i] == AGE_MAX) begin m_valid[i] = 0; m_age[i] = 0; end
                end
            end
        end
        if (tgt >= 0) begin
            m_valid[tgt] = 1; m_ip[tgt] = ip; m_mac[tgt] = mac; m_age[tgt] = 0;
        end
    endtask

    // One clock of stimulus: inputs driven from negedge to negedge.
    task automatic step(input bit a, input logic [31:0] aip, input logic [47:0] amac,
                        input bit t, input bit f, input bit lk, input logic [31:0] lip);
        arp_found = a; arp_rec_source_ip_addr = aip; arp_rec_source_mac_addr = amac;
        age_tick = t; flush = f; lookup_req = lk; destination_ip_addr = lip;
        if (rst_n) begin
            if (lk) exp_q.push_back(model_lookup(lip));
            model_update(a, aip, amac, t, f);
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        step(1, ip, mac, 0, 0, 0, 0);
    endtask

    task automatic look(input logic [31:0] ip);
        step(0, 0, 0, 0, 0, 1, ip);
    endtask

    task automatic tick();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    // Monitor: every lookup_done is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (lookup_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_lookup_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lookup_mac", {16'h0, destination_mac_addr}, {16'h0, e.mac});
                chk("lookup_not_exist", {63'h0, mac_not_exist}, {63'h0, e.nx});
                chk("lookup_entry_count", 64'(entry_count), 64'(e.cnt));
            end
        end
    end

    localparam logic [31:0] NET = 32'hC0A8_0100;

    initial begin
        rst_n = 1'b0;
        arp_found = 0; arp_rec_source_ip_addr = 0; arp_rec_source_mac_addr = 0;
        age_tick = 0; flush = 0; lookup_req = 0; destination_ip_addr = 0;
        @(negedge clk);
        idle(); idle();
        chk("reset_lookup_done", {63'h0, lookup_done}, 64'h0);
        chk("reset_mac", {16'h0, destination_mac_addr}, 64'h0);
        chk("reset_not_exist", {63'h0, mac_not_exist}, 64'h0);
        chk("reset_entry_count", 64'(entry_count), 64'h0);
        rst_n = 1'b1;

        // Learn and hit, miss, relearn with a new MAC.
        learn(32'hC0A8_0102, 48'h0011_2233_4455);
        look(32'hC0A8_0102);
        look(32'hC0A8_0199);
        learn(32'hC0A8_0102, 48'hAABB_CCDD_EEFF);
        look(32'hC0A8_0102);
        idle(); idle();
        chk("relearn_entry_count", 64'(entry_count), 64'd1);

        // Full cache: oldest entry is evicted.
        step(0, 0, 0, 0, 1, 0, 0);
        learn(NET + 1, 48'h0000_0000_0001); tick();
        learn(NET + 2, 48'h0000_0000_0002); tick();
        learn(NET + 3, 48'h0000_0000_0003);
        learn(NET + 4, 48'h0000_0000_0004);
        learn(NET + 5, 48'h0000_0000_0005);
        for (int i = 1; i <= 5; i++) look(NET + 32'(i));
        // Equal ages: lowest index is the victim.
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) learn(NET + 32'(i), 48'(i) << 8);
        for (int i = 1; i <= 5; i++) look(NET + 32'(i));

        // Aging to expiry, then learn on the expiring tick.
        step(0, 0, 0, 0, 1, 0, 0);
        learn(NET + 1, 48'h1111);
        tick(); tick(); tick();
        idle(); idle();
        chk("expired_entry_count", 64'(entry_count), 64'd0);
        look(NET + 1);
        learn(NET + 1, 48'h2222);
        tick(); tick();
        step(1, NET + 1, 48'h3333, 1, 0, 0, 0);
        look(NET + 1);
        tick(); tick();
        look(NET + 1);

        // Flush with learn in the same cycle; lookup with learn in the same cycle.
        step(1, NET + 7, 48'h7777, 0, 1, 1, NET + 1);
        look(NET + 7);
        step(1, NET + 8, 48'h8888, 0, 0, 1, NET + 8);
        look(NET + 8);
        idle();
        // Held outputs survive a flush.
        step(0, 0, 0, 0, 1, 0, 0);
        idle();
        chk("flush_keeps_mac", {16'h0, destination_mac_addr}, 64'h8888);
        chk("flush_keeps_not_exist", {63'h0, mac_not_exist}, 64'h0);

        // Reset with a lookup in flight, then illegal IP learns.
        learn(NET + 3, 48'h3);
        idle();
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 1, NET + 3);
        idle();
        rst_n = 1'b1;
        chk("rst_lookup_done", {63'h0, lookup_done}, 64'h0);
        chk("rst_mac", {16'h0, destination_mac_addr}, 64'h0);
        chk("rst_not_exist", {63'h0, mac_not_exist}, 64'h0);
        chk("rst_entry_count", 64'(entry_count), 64'h0);
        learn(32'h0, 48'h1);
        learn(32'hFFFF_FFFF, 48'h2);
        idle(); idle();
        chk("illegal_ip_entry_count", 64'(entry_count), 64'h0);
        look(32'h0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] aip, lip;
            logic [47:0] amac;
            bit a, t, f, lk;
            a  = ($urandom_range(0, 2) == 0);
            t  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 39) == 0);
            lk = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 15))
                0:       aip = 32'h0;
                1:       aip = 32'hFFFF_FFFF;
                default: aip = NET + 32'($urandom_range(1, 7));
            endcase
            lip  = (($urandom_range(0, 15)) == 0) ? 32'h0 : NET + 32'($urandom_range(1, 7));
            amac = {16'($urandom), $urandom};
            step(a, aip, amac, t, f, lk, lip);
        end

        idle(); idle(); idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lookup_done_missing actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
